acc_src_reg: RTL and testbench
==============================

# acc_src_reg

Parametrised accumulator-source selector with an integrated accumulator register for the BIP-2 datapath. It chooses one of N_SRC equal-width sources (memory data, extension, ULA and any added later) and presents the choice combinationally. On write enable it loads the choice into the accumulator. It also maintains zero/negative flags and a sticky illegal-select error. It replaces the fixed 3-input combinational source mux that feeds the accumulator.

## Interface
- DATA_W, 16, width of each source and of the accumulator
- N_SRC, 3, number of sources (2..16)
- SEL_W, $clog2(N_SRC) (minimum 1), select width; derived, not overridden
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  synchronous active-low reset, sampled on clk_i rising edge
- src_i  in  N_SRC*DATA_W  packed sources; source k occupies bits [k*DATA_W +: DATA_W]
- sel_i  in  SEL_W  source select
- wr_acc_i  in  1  load accumulator this cycle
- clr_err_i  in  1  clear sticky error
- mux_o  out  DATA_W  combinational selected source
- acc_o  out  DATA_W  accumulator register
- z_o  out  1  acc_o == 0 (registered)
- n_o  out  1  acc_o[DATA_W-1] (registered)
- sel_err_o  out  1  sticky: a write was attempted with sel_i >= N_SRC

## Operation
- mux_o = src_i slice sel_i when sel_i < N_SRC, else all zeros; purely combinational, no clock dependence.
- Accumulator update rules:
  - wr_acc_i=1 and sel_i legal: acc_o <= mux_o.
  - wr_acc_i=1 and sel_i illegal: acc_o holds; sel_err_o <= 1.
  - wr_acc_i=0: acc_o holds regardless of sel_i.
- Flags are computed from the value being loaded and register together with acc_o. They never lag acc_o.
- Error flag:
  - Sets only on an illegal select with wr_acc_i=1.
  - Clears on clr_err_i=1.
  - When set and clear occur in the same cycle, set wins.
- Reset (rst_n_i=0 at the edge): acc_o=0, z_o=1, n_o=0, sel_err_o=0. Reset overrides wr_acc_i and clr_err_i in the same cycle.
- Reset asserted mid-sequence discards any load sampled that cycle. The first load is accepted on the first edge with rst_n_i=1.

## Timing
- mux_o: zero-cycle latency from src_i/sel_i.
- acc_o, z_o, n_o: one-cycle latency. They are visible after the rising edge at which wr_acc_i=1 was sampled.
- Back-to-back writes: a write is accepted every cycle, with no bubbles.
- sel_err_o: asserted the cycle after the offending write.
- All state changes occur on the rising edge of clk_i only. No handshake back-pressure.

## Configuration
- ACC_FLAGS_EN defined:
  - z_o and n_o registered as described.
- ACC_FLAGS_EN undefined:
  - Flag registers are not built.
  - z_o and n_o are tied to constant 0, including through reset.
  - Ports remain so instantiations are unchanged.
  - acc_o and sel_err_o behaviour is identical in both cases.

## Structure
- Shared package bip2_acc_pkg:
  - Source index constants SRC_DATA=0, SRC_EXT=1, SRC_ULA=2.
  - Default DATA_W.
  - Function that returns the zero/negative flag pair for a DATA_W value.
- One sub-module, mux_nx1:
  - Parametrised (DATA_W, N_SRC) combinational selector producing mux_o and a legal-select indication.
  - The top level holds only registers and control.

## Test plan
- Reset, then N_SRC=3, DATA_W=11, src = {3,2,1}: sel 0/1/2 with wr_acc_i=0 -> mux_o 1,2,3; acc_o stays 0, z_o=1.
- wr_acc_i=1 for sel=2 then sel=1 on consecutive cycles -> acc_o 3 then 2, on successive edges, z_o=0, n_o=0.
- Load source value 11'h400, then 0 -> n_o=1,z_o=0, then n_o=0,z_o=1, each aligned with acc_o.
- sel=3 with wr_acc_i=1 while acc_o=2 -> mux_o=0, acc_o holds 2, sel_err_o=1 next cycle. Then sel=3 with wr_acc_i=1 and clr_err_i=1 -> remains 1. Then clr_err_i=1 alone -> 0.
- wr_acc_i=1 sel=0 with rst_n_i=0 in the same cycle -> acc_o=0, z_o=1. Next cycle with rst_n_i=1 -> acc_o=1.
- Build without ACC_FLAGS_EN, repeat the flag-alignment scenario (11'h400 then 0) -> z_o=n_o=0 throughout, acc_o identical to the flagged build.

Source files
------------

// File: rtl/bip2_acc_pkg.sv
// Shared definitions for the BIP-2 accumulator source path: source index
// constants, default data width and the zero/negative flag helper.
package bip2_acc_pkg;

  localparam int ACC_DATA_W = 16;
  localparam int MAX_W      = 64;

  localparam int SRC_DATA = 0;
  localparam int SRC_EXT  = 1;
  localparam int SRC_ULA  = 2;

  typedef struct packed {
    logic z;
    logic n;
  } acc_flags_t;

  // Zero/negative flags of a value of width w; the caller zero-extends the
  // value to MAX_W, so the zero test over the full vector is exact.
  function automatic acc_flags_t acc_flags(input logic [MAX_W-1:0] val,
                                           input int unsigned w);
    acc_flags_t f;
    f.z = (val == '0);
    f.n = val[6'(w - 1)];
    return f;
  endfunction

endpackage

// File: rtl/mux_nx1.sv
// N-to-1 combinational selector. Out-of-range selects give all zeros and
// drop the legal indication so the caller can flag the attempt.
module mux_nx1 #(
  parameter int DATA_W = 16,
  parameter int N_SRC  = 3,
  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC*DATA_W-1:0] src,
  input  logic [SEL_W-1:0]        sel,
  output logic [DATA_W-1:0]       mux,
  output logic                    legal
);

  logic [DATA_W-1:0] src_arr [N_SRC];

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_unpack
    assign src_arr[gi] = src[gi*DATA_W +: DATA_W];
  end

  // Pick the matching slice; no match leaves the zero default in place.
  always_comb begin
    mux   = '0;
    legal = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        mux   = src_arr[k];
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/acc_src_reg.sv
// Accumulator source selector with accumulator register, zero/negative
// flags and a sticky illegal-select error.
// Optional feature macro: ACC_FLAGS_EN (builds the z/n flag registers;
// without it z_o and n_o are constant 0).
module acc_src_reg
  import bip2_acc_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W,
  parameter int N_SRC  = 3,
  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [N_SRC*DATA_W-1:0] src_i,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic                    wr_acc_i,
  input  logic                    clr_err_i,
  output logic [DATA_W-1:0]       mux_o,
  output logic [DATA_W-1:0]       acc_o,
  output logic                    z_o,
  output logic                    n_o,
  output logic                    sel_err_o
);

  logic              legal;
  logic              load;
  logic [DATA_W-1:0] acc_reg;
  logic              err_reg;

  mux_nx1 #(
    .DATA_W (DATA_W),
    .N_SRC  (N_SRC)
  ) u_mux (
    .src   (src_i),
    .sel   (sel_i),
    .mux   (mux_o),
    .legal (legal)
  );

  assign load = wr_acc_i && legal;

  // Accumulator: loads the selected source on a legal write, else holds.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      acc_reg <= '0;
    end else if (load) begin
      acc_reg <= mux_o;
    end
  end

  // Sticky error: an illegal write sets it and takes priority over clear.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      err_reg <= 1'b0;
    end else if (wr_acc_i && !legal) begin
      err_reg <= 1'b1;
    end else if (clr_err_i) begin
      err_reg <= 1'b0;
    end
  end

  assign acc_o     = acc_reg;
  assign sel_err_o = err_reg;

`ifdef ACC_FLAGS_EN
  acc_flags_t flags_reg;
  acc_flags_t flags_next;

  assign flags_next = acc_flags(MAX_W'(mux_o), DATA_W);

  // Flags are derived from the value being loaded so they update together
  // with the accumulator rather than a cycle behind it.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      flags_reg <= '{z: 1'b1, n: 1'b0};
    end else if (load) begin
      flags_reg <= flags_next;
    end
  end

  assign z_o = flags_reg.z;
  assign n_o = flags_reg.n;
`else
  assign z_o = 1'b0;
  assign n_o = 1'b0;
`endif

endmodule

// File: tb/tb_acc_src_reg.sv
// Testbench for acc_src_reg (DATA_W=11, N_SRC=3). Expected register state
// is queued when a cycle is driven and compared after the clock edge.
// Flag expectations follow ACC_FLAGS_EN the same way the build does.
module tb_acc_src_reg;

  localparam int DW = 11;
  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS*DW-1:0] src;
  logic [1:0]    sel;
  logic          wr;
  logic          clr;
  logic [DW-1:0] mux;
  logic [DW-1:0] acc;
  logic          z;
  logic          n;
  logic          err;

  logic [DW-1:0] srcs [NS];

  typedef struct {
    logic [DW-1:0] acc;
    logic          z;
    logic          n;
    logic          err;
  } exp_t;

  exp_t exp_q[$];

  logic [DW-1:0] acc_m;
  logic          err_m;
  int            checks = 0;
  int            errors = 0;
  int            txn    = 0;

  acc_src_reg #(
    .DATA_W (DW),
    .N_SRC  (NS)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .src_i     (src),
    .sel_i     (sel),
    .wr_acc_i  (wr),
    .clr_err_i (clr),
    .mux_o     (mux),
    .acc_o     (acc),
    .z_o       (z),
    .n_o       (n),
    .sel_err_o (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (txn %0d)", tag, got, want, txn);
    end
  endtask

  // One cycle: drive inputs, check the combinational mux, queue the model's
  // next state, then compare the registers after the edge.
  task automatic step(input logic [1:0] s, input logic w, input logic c,
                      input logic r);
    exp_t          e;
    logic [DW-1:0] mux_m;
    logic          legal_m;
    @(negedge clk);
    for (int k = 0; k < NS; k++) src[k*DW +: DW] = srcs[k];
    sel   = s;
    wr    = w;
    clr   = c;
    rst_n = r;
    legal_m = (int'(s) < NS);
    mux_m   = legal_m ? srcs[s] : '0;
    #1;
    check("mux", 32'(mux), 32'(mux_m));
    if (!r) begin
      acc_m = '0;
      err_m = 1'b0;
    end else begin
      if (w && legal_m) acc_m = mux_m;
      if (w && !legal_m) err_m = 1'b1;
      else if (c) err_m = 1'b0;
    end
    e.acc = acc_m;
    e.err = err_m;
`ifdef ACC_FLAGS_EN
    e.z = (acc_m == '0);
    e.n = acc_m[DW-1];
`else
    e.z = 1'b0;
    e.n = 1'b0;
`endif
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("acc", 32'(acc), 32'(e.acc));
    check("z", 32'(z), 32'(e.z));
    check("n", 32'(n), 32'(e.n));
    check("err", 32'(err), 32'(e.err));
    $display("txn %0d rst_n=%0b sel=%0d wr=%0b clr=%0b mux=%h acc=%h z=%0b n=%0b err=%0b",
             txn, r, s, w, c, mux, acc, z, n, err);
    txn++;
  endtask

  initial begin
    rst_n = 1'b0;
    sel   = '0;
    wr    = 1'b0;
    clr   = 1'b0;
    src   = '0;
    acc_m = '0;
    err_m = 1'b0;
    srcs[0] = 11'd1;
    srcs[1] = 11'd2;
    srcs[2] = 11'd3;

    // Reset, even with a write and clear pending.
    step(2'd0, 1'b0, 1'b0, 1'b0);
    step(2'd1, 1'b1, 1'b1, 1'b0);

    // Select without writing: mux follows, accumulator stays 0.
    step(2'd0, 1'b0, 1'b0, 1'b1);
    step(2'd1, 1'b0, 1'b0, 1'b1);
    step(2'd2, 1'b0, 1'b0, 1'b1);

    // Back-to-back loads.
    step(2'd2, 1'b1, 1'b0, 1'b1);
    step(2'd1, 1'b1, 1'b0, 1'b1);

    // Flag alignment: negative then zero.
    srcs[0] = 11'h400;
    step(2'd0, 1'b1, 1'b0, 1'b1);
    srcs[0] = 11'h000;
    step(2'd0, 1'b1, 1'b0, 1'b1);
    srcs[0] = 11'd1;
    step(2'd1, 1'b1, 1'b0, 1'b1);

    // Illegal select: hold, set error; set beats clear; clear alone.
    step(2'd3, 1'b1, 1'b0, 1'b1);
    step(2'd3, 1'b0, 1'b0, 1'b1);
    step(2'd3, 1'b1, 1'b1, 1'b1);
    step(2'd0, 1'b0, 1'b1, 1'b1);

    // Reset discards a same-cycle load; next edge loads.
    step(2'd0, 1'b1, 1'b0, 1'b0);
    step(2'd0, 1'b1, 1'b0, 1'b1);

    // Random traffic over the same model.
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < NS; k++) srcs[k] = DW'($urandom);
      step(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 15) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
